// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, MEM-stage port and RAM-side signals around the
// shared data RAM. The arbiter takes the slave view; requesters and the RAM
// model take the master view.
//
// Handshake: a requester raises x_req with stable address/data and holds it
// until the cycle in which x_valid is high. x_gnt marks the single cycle in
// which the request, address and data are sampled and the RAM is driven.
// x_valid is a one-cycle pulse; x_rdata is zero whenever x_valid is low.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_valid;
    logic [DATA_W-1:0] i_rdata;
    // MEM-stage port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    // RAM side
    logic              ram_ce;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    // pipeline stalls
    logic              stall_if;
    logic              stall_mem;
    // observation of internal state for checkers
    logic              dbg_busy;
    logic [7:0]        dbg_starve_cnt;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        output i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
        output ram_ce, ram_we, ram_addr, ram_wdata,
        output stall_if, stall_mem, dbg_busy, dbg_starve_cnt
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        input  i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
        input  ram_ce, ram_we, ram_addr, ram_wdata,
        input  stall_if, stall_mem, dbg_busy, dbg_starve_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between instruction fetch (I)
// and the MEM stage (D). One access is in flight at a time; the grant is decided
// combinationally in IDLE, the RAM is driven in the grant cycle, and the result
// (read data or store ack) comes back to the owner exactly RAM_LAT cycles later.
// D normally wins ties; after STARVE_MAX consecutive losses I is forced to win.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RAM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam int LAT_W = $clog2(RAM_LAT + 1);
    localparam int SW    = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              store_q, store_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    logic              starved;
    logic              grant_i;
    logic              grant_d;

    logic              i_gnt_c, i_valid_c, d_gnt_c, d_valid_c;
    logic [DATA_W-1:0] i_rdata_c, d_rdata_c;
    logic              ram_ce_c, ram_we_c;
    logic [ADDR_W-1:0] ram_addr_c;
    logic [DATA_W-1:0] ram_wdata_c;
    logic              stall_if_c, stall_mem_c;

    // State register; reset drops any in-flight access
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            store_q      <= 1'b0;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            store_q      <= store_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    // Grant decision, latency tracking, starvation counting and all outputs
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        store_d      = store_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;

        starved      = 1'b0;
        grant_i      = 1'b0;
        grant_d      = 1'b0;

        i_gnt_c      = 1'b0;
        i_valid_c    = 1'b0;
        i_rdata_c    = '0;
        d_gnt_c      = 1'b0;
        d_valid_c    = 1'b0;
        d_rdata_c    = '0;
        ram_ce_c     = 1'b0;
        ram_we_c     = 1'b0;
        ram_addr_c   = '0;
        ram_wdata_c  = '0;
        stall_if_c   = 1'b0;
        stall_mem_c  = 1'b0;

        case (state_q)
            IDLE: begin
                starved = (starve_cnt_q == SW'(STARVE_MAX));
                if (bus.d_req && !(bus.i_req && starved)) begin
                    grant_d = 1'b1;
                end else if (bus.i_req) begin
                    grant_i = 1'b1;
                end

                if (grant_d || grant_i) begin
                    i_gnt_c     = grant_i;
                    d_gnt_c     = grant_d;
                    ram_ce_c    = 1'b1;
                    ram_we_c    = grant_d & bus.d_we;
                    ram_addr_c  = grant_d ? bus.d_addr : bus.i_addr;
                    ram_wdata_c = grant_d ? bus.d_wdata : '0;
                    // address/data are held on the RAM bus while BUSY
                    ram_addr_d  = ram_addr_c;
                    ram_wdata_d = ram_wdata_c;
                    owner_d     = grant_d ? OWN_D : OWN_I;
                    store_d     = grant_d & bus.d_we;
                    lat_cnt_d   = LAT_W'(1);
                    state_d     = BUSY;
                end

                // I loses only when it was actually asking
                if (grant_i) begin
                    starve_cnt_d = '0;
                end else if (grant_d && bus.i_req && !starved) begin
                    starve_cnt_d = starve_cnt_q + SW'(1);
                end
            end

            BUSY: begin
                ram_addr_c  = ram_addr_q;
                ram_wdata_c = ram_wdata_q;
                if (lat_cnt_q == LAT_W'(RAM_LAT)) begin
                    if (owner_q == OWN_D) begin
                        d_valid_c = 1'b1;
                        d_rdata_c = store_q ? '0 : bus.ram_rdata;
                    end else begin
                        i_valid_c = 1'b1;
                        i_rdata_c = bus.ram_rdata;
                    end
                    lat_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        stall_if_c  = bus.i_req & ~i_valid_c;
        stall_mem_c = bus.d_req & ~d_valid_c;

        // every output is forced low while reset is held
        if (rst) begin
            i_gnt_c     = 1'b0;
            i_valid_c   = 1'b0;
            i_rdata_c   = '0;
            d_gnt_c     = 1'b0;
            d_valid_c   = 1'b0;
            d_rdata_c   = '0;
            ram_ce_c    = 1'b0;
            ram_we_c    = 1'b0;
            ram_addr_c  = '0;
            ram_wdata_c = '0;
            stall_if_c  = 1'b0;
            stall_mem_c = 1'b0;
        end
    end

    assign bus.i_gnt          = i_gnt_c;
    assign bus.i_valid        = i_valid_c;
    assign bus.i_rdata        = i_rdata_c;
    assign bus.d_gnt          = d_gnt_c;
    assign bus.d_valid        = d_valid_c;
    assign bus.d_rdata        = d_rdata_c;
    assign bus.ram_ce         = ram_ce_c;
    assign bus.ram_we         = ram_we_c;
    assign bus.ram_addr       = ram_addr_c;
    assign bus.ram_wdata      = ram_wdata_c;
    assign bus.stall_if       = stall_if_c;
    assign bus.stall_mem      = stall_mem_c;
    assign bus.dbg_busy       = (state_q == BUSY);
    assign bus.dbg_starve_cnt = 8'(starve_cnt_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with RAM_LAT=1 for the
// main sequences and one with RAM_LAT=3 for the reset-during-access case.
module tb_mem_port_arbiter;

  logic clk;
  logic rst1;
  logic rst3;
  int   n_vec;
  int   n_err;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // background contents of the RAM models
  function automatic logic [31:0] ram_val(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return (a ^ 32'h5A5A_0000) + 32'h1;
  endfunction

  // RAM model for dut1: latency 1, writable over a small window
  logic [31:0] mem1 [0:255];
  logic [255:0] wr_v1;
  logic [31:0] rd1;

  always @(posedge clk) begin
    if (rst1) begin
      wr_v1 <= '0;
    end else if (bus1.ram_ce && bus1.ram_we) begin
      mem1[bus1.ram_addr[9:2]]  <= bus1.ram_wdata;
      wr_v1[bus1.ram_addr[9:2]] <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (bus1.ram_ce && !bus1.ram_we)
      rd1 <= wr_v1[bus1.ram_addr[9:2]] ? mem1[bus1.ram_addr[9:2]] : ram_val(bus1.ram_addr);
  end

  assign bus1.ram_rdata = rd1;

  // RAM model for dut3: read-only, latency 3
  logic [31:0] p3_0, p3_1, p3_2;

  always @(posedge clk) begin
    p3_0 <= (bus3.ram_ce && !bus3.ram_we) ? ram_val(bus3.ram_addr) : 32'h0;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end

  assign bus3.ram_rdata = p3_2;

  // scoreboard
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle1();
    bus1.i_req   = 1'b0;
    bus1.i_addr  = '0;
    bus1.d_req   = 1'b0;
    bus1.d_we    = 1'b0;
    bus1.d_addr  = '0;
    bus1.d_wdata = '0;
  endtask

  task automatic idle3();
    bus3.i_req   = 1'b0;
    bus3.i_addr  = '0;
    bus3.d_req   = 1'b0;
    bus3.d_we    = 1'b0;
    bus3.d_addr  = '0;
    bus3.d_wdata = '0;
  endtask

  task automatic chk_zero1(input string tag);
    check({tag, "_i_gnt"},     32'(bus1.i_gnt),     32'h0);
    check({tag, "_d_gnt"},     32'(bus1.d_gnt),     32'h0);
    check({tag, "_valids"},    32'({bus1.i_valid, bus1.d_valid}), 32'h0);
    check({tag, "_ram_ctl"},   32'({bus1.ram_ce, bus1.ram_we}),   32'h0);
    check({tag, "_ram_addr"},  bus1.ram_addr,       32'h0);
    check({tag, "_stalls"},    32'({bus1.stall_if, bus1.stall_mem}), 32'h0);
  endtask

  initial begin
    int grants;
    int prev_c;
    logic [31:0] e;

    n_vec = 0;
    n_err = 0;
    rst1  = 1'b1;
    rst3  = 1'b1;
    idle1();
    idle3();

    // 1: reset with both requesting, then D wins first
    bus1.i_req  = 1'b1;
    bus1.i_addr = 32'h44;
    bus1.d_req  = 1'b1;
    bus1.d_addr = 32'h200;
    repeat (2) begin
      settle();
      chk_zero1("rst");
    end
    cyc();
    rst1 = 1'b0;
    rst3 = 1'b0;
    settle();
    check("t1_d_gnt",    32'(bus1.d_gnt),   32'h1);
    check("t1_i_gnt",    32'(bus1.i_gnt),   32'h0);
    check("t1_ram_addr", bus1.ram_addr,     32'h200);
    check("t1_stalls",   32'({bus1.stall_if, bus1.stall_mem}), 32'h3);
    cyc();
    settle();
    check("t1_d_valid",  32'(bus1.d_valid), 32'h1);
    check("t1_d_rdata",  bus1.d_rdata,      ram_val(32'h200));
    check("t1_busy_gnt", 32'(bus1.i_gnt),   32'h0);
    check("t1_stall_mem", 32'(bus1.stall_mem), 32'h0);
    cyc();
    idle1();
    settle();
    check("t1_idle_ce",  32'(bus1.ram_ce),  32'h0);
    check("t1_starve",   32'(bus1.dbg_starve_cnt), 32'h1);
    check("t1_busy",     32'(bus1.dbg_busy), 32'h0);

    // 2: fetch only, RAM returns 0xDEADBEEF
    cyc();
    bus1.i_req  = 1'b1;
    bus1.i_addr = 32'h40;
    settle();
    check("t2_i_gnt",    32'(bus1.i_gnt),   32'h1);
    check("t2_ram_ce",   32'(bus1.ram_ce),  32'h1);
    check("t2_ram_we",   32'(bus1.ram_we),  32'h0);
    check("t2_ram_addr", bus1.ram_addr,     32'h40);
    check("t2_stall_if", 32'(bus1.stall_if), 32'h1);
    check("t2_i_rdata0", bus1.i_rdata,      32'h0);
    cyc();
    settle();
    check("t2_i_valid",  32'(bus1.i_valid), 32'h1);
    check("t2_i_rdata",  bus1.i_rdata,      32'hDEADBEEF);
    check("t2_stall_if1", 32'(bus1.stall_if), 32'h0);
    check("t2_ram_ce1",  32'(bus1.ram_ce),  32'h0);
    check("t2_addr_hold", bus1.ram_addr,    32'h40);
    check("t2_starve",   32'(bus1.dbg_starve_cnt), 32'h0);
    cyc();
    idle1();

    // 3: store then load back through the RAM model
    bus1.d_req   = 1'b1;
    bus1.d_we    = 1'b1;
    bus1.d_addr  = 32'h100;
    bus1.d_wdata = 32'h12345678;
    settle();
    check("t3_d_gnt",     32'(bus1.d_gnt),  32'h1);
    check("t3_ram_ctl",   32'({bus1.ram_ce, bus1.ram_we}), 32'h3);
    check("t3_ram_addr",  bus1.ram_addr,    32'h100);
    check("t3_ram_wdata", bus1.ram_wdata,   32'h12345678);
    cyc();
    settle();
    check("t3_d_valid",   32'(bus1.d_valid), 32'h1);
    check("t3_d_rdata",   bus1.d_rdata,     32'h0);
    check("t3_ram_we1",   32'(bus1.ram_we), 32'h0);
    check("t3_wdata_hold", bus1.ram_wdata,  32'h12345678);
    cyc();
    bus1.d_we    = 1'b0;
    bus1.d_wdata = '0;
    settle();
    check("t3_ld_gnt",    32'(bus1.d_gnt),  32'h1);
    cyc();
    settle();
    check("t3_ld_rdata",  bus1.d_rdata,     32'h12345678);
    cyc();
    idle1();

    // 4: both held continuously -> D,D,D,D,I,D,D,D,D,I every 2 cycles
    for (int k = 0; k < 10; k++) exp_q.push_back((k == 4 || k == 9) ? 32'h1 : 32'h0);
    bus1.i_req  = 1'b1;
    bus1.i_addr = 32'h300;
    bus1.d_req  = 1'b1;
    bus1.d_addr = 32'h304;
    grants = 0;
    prev_c = 0;
    for (int c = 0; c < 40 && grants < 10; c++) begin
      settle();
      if (bus1.i_gnt || bus1.d_gnt) begin
        check("t4_excl", 32'(bus1.i_gnt & bus1.d_gnt), 32'h0);
        e = exp_q.pop_front();
        check($sformatf("t4_order%0d", grants), 32'(bus1.i_gnt), e);
        if (grants > 0) check($sformatf("t4_gap%0d", grants), 32'(c - prev_c), 32'h2);
        prev_c = c;
        grants++;
      end
      cyc();
    end
    check("t4_grants", 32'(grants), 32'd10);
    settle();
    check("t4_last_i_valid", 32'(bus1.i_valid), 32'h1);
    check("t4_last_i_rdata", bus1.i_rdata, ram_val(32'h300));
    cyc();
    idle1();

    // 6: one-cycle fetch pulse while BUSY is ignored
    bus1.d_req  = 1'b1;
    bus1.d_addr = 32'h3F0;
    settle();
    check("t6_d_gnt", 32'(bus1.d_gnt), 32'h1);
    cyc();
    bus1.i_req  = 1'b1;
    bus1.i_addr = 32'h3F4;
    settle();
    check("t6_busy_i_gnt", 32'(bus1.i_gnt), 32'h0);
    check("t6_busy_ce",    32'(bus1.ram_ce), 32'h0);
    check("t6_d_valid",    32'(bus1.d_valid), 32'h1);
    cyc();
    idle1();
    settle();
    check("t6_i_gnt",  32'(bus1.i_gnt),  32'h0);
    check("t6_ram_ce", 32'(bus1.ram_ce), 32'h0);
    check("t6_starve", 32'(bus1.dbg_starve_cnt), 32'h0);
    cyc();

    // 5: RAM_LAT=3, reset hits a D load in flight; pending I served after
    bus3.d_req  = 1'b1;
    bus3.d_addr = 32'h80;
    settle();
    check("t5_d_gnt", 32'(bus3.d_gnt), 32'h1);
    cyc();
    rst3 = 1'b1;
    idle3();
    bus3.i_req  = 1'b1;
    bus3.i_addr = 32'h60;
    settle();
    check("t5_rst_outs", 32'({bus3.i_gnt, bus3.d_gnt, bus3.d_valid, bus3.i_valid,
                              bus3.ram_ce, bus3.stall_if, bus3.stall_mem}), 32'h0);
    cyc();
    rst3 = 1'b0;
    settle();
    check("t5_i_gnt",    32'(bus3.i_gnt),   32'h1);
    check("t5_ram_addr", bus3.ram_addr,     32'h60);
    check("t5_no_dv0",   32'(bus3.d_valid), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      settle();
      check($sformatf("t5_no_dv%0d", k), 32'(bus3.d_valid), 32'h0);
      check($sformatf("t5_i_valid%0d", k), 32'(bus3.i_valid), (k == 3) ? 32'h1 : 32'h0);
      check($sformatf("t5_i_rdata%0d", k), bus3.i_rdata, (k == 3) ? ram_val(32'h60) : 32'h0);
    end
    cyc();
    idle3();
    settle();
    check("t5_end_ce", 32'(bus3.ram_ce), 32'h0);
    cyc();

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
